// File: rtl/syn_syscall_unit.sv
// Syscall decode, display FIFO and run-state machine (RUN/PAUSED/STEP/EXITED) for the CPU top.
// Latency: halt is combinational; FIFO head visible the cycle after a push into an empty FIFO; exited one edge after the exit syscall.
// Backpressure: halt stalls the CPU only when a display push meets a full FIFO with no pop, or while paused/exited.
//
// Ports: clk/rst_n (sync active-low), en (CPU step enable), syscall_en/data_v0/data_a0 (request),
//        resume (debounced button, edge-detected), disp_rd (display pop),
//        disp_data/disp_dec/disp_valid/fifo_count (FIFO head and occupancy), halt, exited.
module syn_syscall_unit #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int V0_HEX     = 34,
    parameter int V0_DEC     = 1,
    parameter int V0_EXIT    = 10,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              syscall_en,
    input  logic [DATA_W-1:0] data_v0,
    input  logic [DATA_W-1:0] data_a0,
    input  logic              resume,
    input  logic              disp_rd,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_dec,
    output logic              disp_valid,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              halt,
    output logic              exited
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [DATA_W-1:0] HEX_CODE  = DATA_W'(V0_HEX);
    localparam logic [DATA_W-1:0] DEC_CODE  = DATA_W'(V0_DEC);
    localparam logic [DATA_W-1:0] EXIT_CODE = DATA_W'(V0_EXIT);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_STEP   = 2'd2,
        ST_EXITED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              resume_q;
    logic              exited_q, exited_d;
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
    logic              dec_mem_q  [FIFO_DEPTH];

    logic is_disp, is_exit, is_pause, is_dec, full, empty, res_edge;
    logic push_ok, pop_ok;

    always_comb begin
        is_dec   = (data_v0 == DEC_CODE);
        is_disp  = syscall_en & ((data_v0 == HEX_CODE) | is_dec);
        is_exit  = syscall_en & (data_v0 == EXIT_CODE);
        is_pause = syscall_en & ~is_disp & ~is_exit;
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        res_edge = resume & ~resume_q;

        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok  = en & (state_q == ST_RUN) & is_disp & (~full | disp_rd);
        // Pops run regardless of en; the display side has its own pace.
        pop_ok   = disp_rd & ~empty;

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
        if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);

        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_RUN: begin
                    if (is_pause)     state_d = ST_PAUSED;
                    else if (is_exit) state_d = ST_EXITED;
                end
                ST_PAUSED: if (res_edge) state_d = ST_STEP;
                ST_STEP:   state_d = ST_RUN;
                default:   state_d = ST_EXITED;
            endcase
        end
        exited_d = (state_d == ST_EXITED);

        // STEP ignores syscall_en so the pausing syscall retires exactly once.
        case (state_q)
            ST_RUN:    halt = (is_disp & full & ~disp_rd) | is_pause | is_exit;
            ST_STEP:   halt = 1'b0;
            default:   halt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            resume_q <= 1'b0;
            exited_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            resume_q <= resume;
            exited_q <= exited_d;
        end
    end

    // Payload storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            data_mem_q[wr_ptr_q] <= data_a0;
            dec_mem_q[wr_ptr_q]  <= is_dec;
        end
    end

    assign disp_valid = ~empty;
    assign disp_data  = empty ? '0 : data_mem_q[rd_ptr_q];
    assign disp_dec   = empty ? 1'b0 : dec_mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign exited     = exited_q;

endmodule

// File: tb/tb_syn_syscall_unit.sv
// Bench for syn_syscall_unit: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference of the run/display rules.
// Inputs change 1 time unit after the rising edge; outputs sampled 3 units after it.
module tb_syn_syscall_unit;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n, en, syscall_en, resume, disp_rd;
    logic [DW-1:0] data_v0, data_a0;
    logic [DW-1:0] disp_data;
    logic          disp_dec, disp_valid, halt, exited;
    logic [CW-1:0] fifo_count;

    syn_syscall_unit #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .syscall_en(syscall_en),
        .data_v0(data_v0), .data_a0(data_a0), .resume(resume), .disp_rd(disp_rd),
        .disp_data(disp_data), .disp_dec(disp_dec), .disp_valid(disp_valid),
        .fifo_count(fifo_count), .halt(halt), .exited(exited)
    );

    always #5 clk = ~clk;

    // Reference: display entries as a queue of {dec, data}; run mode by name.
    localparam int M_RUN = 0, M_PAUSED = 1, M_STEP = 2, M_EXITED = 3;
    logic [DW:0] mq [$];
    int          mode;
    bit          res_prev;
    bit          m_exited;

    int  n_assert = 0;
    int  n_fail   = 0;
    bit  chk_on   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_halt(input bit s, input logic [DW-1:0] v0, input bit rd);
        bit disp, ex, pz, full;
        disp = s && (v0 == 34 || v0 == 1);
        ex   = s && (v0 == 10);
        pz   = s && !disp && !ex;
        full = (mq.size() == DEPTH);
        case (mode)
            M_RUN:   return (disp && full && !rd) || pz || ex;
            M_STEP:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic ref_edge(input bit r, input bit e, input bit s, input logic [DW-1:0] v0,
                            input logic [DW-1:0] a0, input bit res, input bit rd);
        bit disp, ex, pz, push, pop;
        if (!r) begin
            mode = M_RUN; mq.delete(); res_prev = 0; m_exited = 0;
            return;
        end
        disp = s && (v0 == 34 || v0 == 1);
        ex   = s && (v0 == 10);
        pz   = s && !disp && !ex;
        pop  = rd && mq.size() > 0;
        push = e && mode == M_RUN && disp && (mq.size() < DEPTH || rd);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back({(v0 == 1), a0});
        if (e) begin
            if (mode == M_RUN && pz)           mode = M_PAUSED;
            else if (mode == M_RUN && ex)      mode = M_EXITED;
            else if (mode == M_PAUSED && res && !res_prev) mode = M_STEP;
            else if (mode == M_STEP)           mode = M_RUN;
        end
        m_exited = (mode == M_EXITED);
        res_prev = res;
    endtask

    // One clock cycle: drive, check the settled outputs, advance the reference at the edge.
    task automatic step(input bit r, input bit e, input bit s, input logic [DW-1:0] v0,
                        input logic [DW-1:0] a0, input bit res, input bit rd);
        logic [DW:0] head;
        rst_n = r; en = e; syscall_en = s; data_v0 = v0; data_a0 = a0; resume = res; disp_rd = rd;
        #2;
        if (chk_on) begin
            head = (mq.size() > 0) ? mq[0] : '0;
            chk("halt",       64'(halt),       64'(ref_halt(s, v0, rd)));
            chk("disp_valid", 64'(disp_valid), 64'(mq.size() > 0));
            chk("disp_data",  64'(disp_data),  64'(head[DW-1:0]));
            chk("disp_dec",   64'(disp_dec),   64'(head[DW]));
            chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
            chk("exited",     64'(exited),     64'(m_exited));
        end
        @(posedge clk);
        ref_edge(r, e, s, v0, a0, res, rd);
        #1;
    endtask

    task automatic idle(input bit rd);
        step(1, 1, 0, 0, 0, 0, rd);
    endtask

    initial begin
        mode = M_RUN; res_prev = 0; m_exited = 0;
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk_on = 1;

        // Reset state
        idle(0);
        chk("reset_count_const", 64'(fifo_count), 64'd0);

        // Two display syscalls, then pop
        step(1, 1, 1, 34, 32'hDEADBEEF, 0, 0);
        step(1, 1, 1, 1,  32'h0000002A, 0, 0);
        idle(0);
        chk("two_push_head", 64'(disp_data), 64'hDEADBEEF);
        chk("two_push_cnt",  64'(fifo_count), 64'd2);
        idle(1);
        idle(0);
        chk("pop_head", 64'(disp_data), 64'h2A);
        chk("pop_dec",  64'(disp_dec),  64'd1);
        idle(1);

        // Fill to full, stall, then pop-while-push on full
        for (int i = 0; i < 5; i++) step(1, 1, 1, 34, 32'h100 + i, 0, 0);
        chk("full_stall_halt", 64'(halt), 64'd1);
        step(1, 1, 1, 34, 32'h104, 0, 1);
        idle(0);
        chk("full_swap_head", 64'(disp_data), 64'h101);
        for (int i = 0; i < 4; i++) idle(1);
        idle(1);   // pop on empty

        // Pause, resume held 3 cycles, syscall held through STEP
        step(1, 1, 1, 5, 0, 0, 0);
        step(1, 1, 1, 5, 0, 0, 0);
        step(1, 1, 1, 5, 0, 1, 0);
        step(1, 1, 1, 5, 0, 1, 0);  // STEP: halt must be 0
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 1, 5, 0, 0, 0);  // pauses again
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(0);

        // Exit, ignored inputs, reset out of exit
        step(1, 1, 1, 34, 32'h55, 0, 0);
        step(1, 1, 1, 10, 0, 0, 0);
        idle(0);
        chk("exited_const", 64'(exited), 64'd1);
        step(1, 1, 1, 34, 32'h77, 1, 0);
        step(1, 1, 1, 34, 32'h77, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(0);

        // en=0 freezes state/pushes but not pops
        step(1, 1, 1, 34, 32'hA1, 0, 0);
        step(1, 1, 1, 1,  32'hA2, 0, 0);
        step(1, 0, 1, 5, 0, 0, 0);
        step(1, 0, 1, 34, 32'hA3, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 5, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);  // edge lost while frozen
        step(1, 1, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0);
        idle(0);
        idle(0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [DW-1:0] v0;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel < 7)       v0 = 34;
            else if (sel < 13) v0 = 1;
            else if (sel < 14) v0 = 10;
            else if (sel < 17) v0 = 5;
            else               v0 = $urandom;
            step(($urandom_range(0, 29) != 0), ($urandom_range(0, 4) != 0),
                 $urandom_range(0, 1), v0, $urandom,
                 $urandom_range(0, 1), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_syscall_unit.md
Name: syn_syscall_unit

Overview:
- Sequential, parametrised successor to the combinational syscall block, driven by the CPU top.
- Decodes syscall requests using $v0 and $a0 as the argument registers.
- Buffers display requests in a FIFO, so the 7-segment driver consumes values at its own pace. The CPU stalls only when the FIFO is full.
- Adds three run states alongside running: a pause state with resume/single-step, and a terminal exit state.

Parameters:
- DATA_W, 32: width of the $v0 / $a0 data and FIFO payload.
- FIFO_DEPTH, 4: number of display entries; must be a power of 2 and at least 2.
- V0_HEX, 34: $v0 code for "display $a0 as hex".
- V0_DEC, 1: $v0 code for "display $a0 as decimal".
- V0_EXIT, 10: $v0 code for "terminate program".
- CNT_W, $clog2(FIFO_DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  Clock; all state changes on the rising edge.
- rst_n  in  1  Synchronous active-low reset.
- en  in  1  CPU step enable; when 0, the run state machine is frozen.
- syscall_en  in  1  The current instruction is a syscall.
- data_v0  in  DATA_W  Value of $v0.
- data_a0  in  DATA_W  Value of $a0.
- resume  in  1  Resume request from a button, already debounced; rising-edge sensitive.
- disp_rd  in  1  Display side pops the FIFO head.
- disp_data  out  DATA_W  FIFO head payload; 0 when the FIFO is empty.
- disp_dec  out  1  FIFO head mode: 1 = decimal, 0 = hex; 0 when empty.
- disp_valid  out  1  FIFO is non-empty.
- fifo_count  out  CNT_W  Number of occupied entries.
- halt  out  1  CPU must not retire the current instruction or advance PC (combinational).
- exited  out  1  Program has terminated (registered).

Behaviour:
- Reset:
  - When rst_n is 0 at a clock edge: state becomes RUN, FIFO pointers and count clear, resume edge register clears, exited is 0.
  - Outputs after reset: disp_valid=0, disp_data=0, disp_dec=0, fifo_count=0.
  - halt follows its combinational equation; with syscall_en=0 it is 0.
  - Reset has priority over every other event, including reset during PAUSED, EXITED or a FIFO-full stall.
- Derived signals:
  - is_disp = syscall_en & (v0==V0_HEX | v0==V0_DEC).
  - is_exit = syscall_en & v0==V0_EXIT.
  - is_pause = syscall_en & !is_disp & !is_exit.
  - full = (count==FIFO_DEPTH).
  - res_edge = resume & !resume_q. resume_q is registered every cycle, regardless of en.
- States: RUN, PAUSED, STEP, EXITED (2-bit encoding).
- RUN:
  - halt = (is_disp & full & !disp_rd) | is_pause | is_exit.
  - On an edge with en=1:
    - is_disp and the push is accepted (not full, or disp_rd=1 in the same cycle): write {v0==V0_DEC, a0} to the tail. The CPU retires the instruction in this cycle.
    - is_disp and full with no pop: no write, stay in RUN. The instruction retries next cycle.
    - is_pause: go to PAUSED.
    - is_exit: go to EXITED.
- PAUSED:
  - halt=1.
  - res_edge (with en=1) takes the state to STEP; otherwise stay in PAUSED.
- STEP:
  - halt=0 and syscall_en is ignored, so the pausing syscall retires exactly once.
  - On an edge with en=1, go to RUN.
- EXITED:
  - halt=1 and exited=1 until reset. resume and syscall_en are ignored.
  - exited is registered and rises on the edge that enters EXITED.
- en=0:
  - State and pushes are frozen. halt is still computed as above.
  - Pops (disp_rd) and resume_q still update; the display side is independent of en.
- FIFO:
  - Circular buffer with DEPTH entries; read and write pointers wrap modulo FIFO_DEPTH.
  - disp_rd while empty: ignored, and count does not underflow.
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Pop on full plus push: accepted, count stays at FIFO_DEPTH.
  - A head write and read in the same cycle return the old head.
- Latency:
  - A pushed entry becomes visible on disp_data the cycle after the push edge if the FIFO was empty.
  - halt responds combinationally within the same cycle.

Test Plan:
- Reset then idle → halt=0, disp_valid=0, fifo_count=0, exited=0, disp_data=0.
- Two syscalls, v0=34/a0=0xDEADBEEF then v0=1/a0=0x2A, one cycle each, disp_rd=0 → halt=0 on both; fifo_count=2; head is 0xDEADBEEF with disp_dec=0. Pop → head 0x2A, disp_dec=1.
- Five v0=34 syscalls held with disp_rd=0 (DEPTH=4) → fifth cycle halt=1, count stays 4. Assert disp_rd for one cycle → halt=0 in that cycle, push accepted, count=4, head advances.
- v0=5 syscall → halt=1 in the same cycle, PAUSED. Hold resume=1 for 3 cycles → exactly one STEP cycle with halt=0, then RUN. Repeat the syscall → halt=1 again.
- v0=10 syscall → halt=1, exited=1 next edge. Pulse resume and syscall with v0=34 → no change, count unchanged. rst_n=0 for one edge → RUN, exited=0.
- en=0 with v0=5 syscall → halt=1, state stays RUN. Raise en → PAUSED. Pops with en=0 still decrement fifo_count; disp_rd while empty leaves count at 0.
